// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell evaluated per clock.
// An accepted start captures ain/bin/cin. WIDTH RUN cycles then add the operands
// LSB first, and a single DONE cycle presents the result with a done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered
// two's-complement overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   // Bit-counter width. It is kept at least 1 bit so that WIDTH=1 still has a legal vector.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;

   // Working registers: captured operands, running carry, partial sum, bit index.
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] s_r;
   logic             c_r;
   logic [CW-1:0]    cnt;

   logic             fa_s;
   logic             fa_c;
   logic             last_bit;
   logic [WIDTH-1:0] s_nx;

   // The one full-adder cell, and the partial sum with the current bit merged in.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      fa_s     = a_r[cnt] ^ b_r[cnt] ^ c_r;
      fa_c     = (a_r[cnt] & b_r[cnt]) | (c_r & (a_r[cnt] ^ b_r[cnt]));
      last_bit = (cnt == CW'(WIDTH - 1));
      s_nx     = s_r;
      s_nx[cnt] = fa_s;
   end

   // State register. Reset wins over every transition.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic and the status outputs decoded from the state.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: capture on accept, one bit per RUN cycle, publish on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the working registers are cleared along with the results, so an
         // aborted addition leaves no partial state behind.
         a_r  <= '0;
         b_r  <= '0;
         s_r  <= '0;
         c_r  <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r <= ain;
                  b_r <= bin;
                  c_r <= cin;
                  s_r <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               s_r <= s_nx;
               c_r <= fa_c;
               cnt <= cnt + CW'(1);
               if (last_bit) begin
                  // The final bit is taken straight from the adder cell, so the
                  // result is complete on the edge that enters DONE.
                  sum  <= s_nx;
                  cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                  // c_r still holds the carry into the MSB at this point.
                  ovf  <= c_r ^ fa_c;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
